// File: rtl/arm_pkg.sv
// Shared definitions for the execute-stage conditional-execution logic.
//   cond_e  : the 16 ARM condition-field encodings
//   FLAG_*  : bit positions of N, Z, C, V inside the 4-bit flags word
package arm_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_e2m_if.sv
// Bundle between the execute stage and the cond_e2m unit.
//   master : execute-stage side, drives E-stage control, stall/flush;
//            receives condition result, branch redirect, flags and M controls
//   slave  : the cond_e2m unit itself
interface cond_e2m_if #(
  parameter int REG_ADDR_W = 4,
  parameter int COND_W     = 4
);
  logic                  StallM;
  logic                  FlushM;
  logic [COND_W-1:0]     CondE;
  logic [3:0]            ALUFlagsE;
  logic [1:0]            FlagWriteE;
  logic                  PCSrcE;
  logic                  BranchE;
  logic                  RegWriteE;
  logic                  MemWriteE;
  logic                  MemtoRegE;
  logic [REG_ADDR_W-1:0] WA3E;

  logic                  BranchTakenE;
  logic                  CondExE;
  logic [3:0]            FlagsQ;
  logic                  PCSrcM;
  logic                  RegWriteM;
  logic                  MemWriteM;
  logic                  MemtoRegM;
  logic [REG_ADDR_W-1:0] WA3M;

  modport master (
    output StallM, FlushM, CondE, ALUFlagsE, FlagWriteE, PCSrcE, BranchE,
           RegWriteE, MemWriteE, MemtoRegE, WA3E,
    input  BranchTakenE, CondExE, FlagsQ, PCSrcM, RegWriteM, MemWriteM,
           MemtoRegM, WA3M
  );

  modport slave (
    input  StallM, FlushM, CondE, ALUFlagsE, FlagWriteE, PCSrcE, BranchE,
           RegWriteE, MemWriteE, MemtoRegE, WA3E,
    output BranchTakenE, CondExE, FlagsQ, PCSrcM, RegWriteM, MemWriteM,
           MemtoRegM, WA3M
  );
endinterface

// File: rtl/cond_check.sv
// Purely combinational ARM condition evaluator.
//   cond    : 4-bit condition field
//   flags   : current {N,Z,C,V}
//   cond_ex : 1 when the instruction is allowed to take effect
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b1;
    case (cond_e'(cond))
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = ~(n ^ v);
      COND_LT: cond_ex = n ^ v;
      COND_GT: cond_ex = ~z & ~(n ^ v);
      COND_LE: cond_ex = z | (n ^ v);
      COND_AL: cond_ex = 1'b1;
      // The reserved encoding executes unconditionally.
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_e2m.sv
// Execute-stage conditional-execution unit fused with the E->M control register.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus (slave)  : E-stage controls in; CondExE / BranchTakenE (combinational),
//                  FlagsQ and registered M-stage controls out
// The condition is evaluated against the architectural flags, so an
// instruction sees flags written by its predecessor one cycle earlier.
module cond_e2m
  import arm_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int COND_W     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  cond_e2m_if.slave  bus
);

  logic [3:0]            flags_reg;
  logic                  cond_ex;
  logic                  pcsrc_reg;
  logic                  regwrite_reg;
  logic                  memwrite_reg;
  logic                  memtoreg_reg;
  logic [REG_ADDR_W-1:0] wa3_reg;
  logic                  flag_en;

  cond_check u_cond_check (
    .cond    (bus.CondE[3:0]),
    .flags   (flags_reg),
    .cond_ex (cond_ex)
  );

  // Flags move only when the instruction really retires from E this cycle.
  assign flag_en = cond_ex & ~bus.StallM & ~bus.FlushM;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_reg <= 4'b0000;
    end else if (flag_en) begin
      if (bus.FlagWriteE[1]) begin
        flags_reg[FLAG_N] <= bus.ALUFlagsE[FLAG_N];
        flags_reg[FLAG_Z] <= bus.ALUFlagsE[FLAG_Z];
      end
      if (bus.FlagWriteE[0]) begin
        flags_reg[FLAG_C] <= bus.ALUFlagsE[FLAG_C];
        flags_reg[FLAG_V] <= bus.ALUFlagsE[FLAG_V];
      end
    end
  end

  // Flush beats stall: a flushed slot always becomes a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcsrc_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      memwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
      wa3_reg      <= '0;
    end else if (bus.FlushM) begin
      pcsrc_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      memwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
      wa3_reg      <= '0;
    end else if (!bus.StallM) begin
      pcsrc_reg    <= bus.PCSrcE    & cond_ex;
      regwrite_reg <= bus.RegWriteE & cond_ex;
      memwrite_reg <= bus.MemWriteE & cond_ex;
      // Harmless to pass through: without RegWriteM nothing is written back.
      memtoreg_reg <= bus.MemtoRegE;
      wa3_reg      <= bus.WA3E;
    end
  end

  assign bus.CondExE      = cond_ex;
  assign bus.BranchTakenE = bus.BranchE & cond_ex;
  assign bus.FlagsQ       = flags_reg;
  assign bus.PCSrcM       = pcsrc_reg;
  assign bus.RegWriteM    = regwrite_reg;
  assign bus.MemWriteM    = memwrite_reg;
  assign bus.MemtoRegM    = memtoreg_reg;
  assign bus.WA3M         = wa3_reg;

endmodule

// File: tb/tb_cond_e2m.sv
// Self-checking bench for cond_e2m: a reference model predicts the E-stage
// combinational results and the next M-stage state; predictions are queued
// at drive time and popped after the following clock edge.
module tb_cond_e2m;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  cond_e2m_if #(.REG_ADDR_W(4), .COND_W(4)) bus ();

  cond_e2m #(.REG_ADDR_W(4), .COND_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pcsrc;
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic [3:0] wa3;
    logic [3:0] flags;
    logic       condex;
    logic       btaken;
  } exp_t;

  exp_t       sb[$];
  exp_t       last_m;
  logic [3:0] m_flags;

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cc;
      4'd3:  return !cc;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cc && !z;
      4'd9:  return !cc || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_flags         = 4'b0000;
    last_m.pcsrc    = 1'b0;
    last_m.regwrite = 1'b0;
    last_m.memwrite = 1'b0;
    last_m.memtoreg = 1'b0;
    last_m.wa3      = 4'h0;
    last_m.flags    = 4'b0000;
    last_m.condex   = 1'b0;
    last_m.btaken   = 1'b0;
    sb.delete();
  endtask

  // Apply one E-stage instruction and queue the predicted outcome.
  task automatic drive(input logic [3:0] cond, input logic [3:0] alu,
                       input logic [1:0] fw, input logic pc, input logic br,
                       input logic rw, input logic mw, input logic m2r,
                       input logic [3:0] wa, input logic st, input logic fl);
    exp_t e;
    logic cx;
    bus.CondE      = cond;
    bus.ALUFlagsE  = alu;
    bus.FlagWriteE = fw;
    bus.PCSrcE     = pc;
    bus.BranchE    = br;
    bus.RegWriteE  = rw;
    bus.MemWriteE  = mw;
    bus.MemtoRegE  = m2r;
    bus.WA3E       = wa;
    bus.StallM     = st;
    bus.FlushM     = fl;
    cx = ref_cond(cond, m_flags);
    e  = last_m;
    e.condex = cx;
    e.btaken = br & cx;
    if (fl) begin
      e.pcsrc = 0; e.regwrite = 0; e.memwrite = 0; e.memtoreg = 0; e.wa3 = 0;
    end else if (!st) begin
      e.pcsrc = pc & cx; e.regwrite = rw & cx; e.memwrite = mw & cx;
      e.memtoreg = m2r; e.wa3 = wa;
    end
    e.flags = m_flags;
    if (cx && !st && !fl) begin
      if (fw[1]) e.flags[3:2] = alu[3:2];
      if (fw[0]) e.flags[1:0] = alu[1:0];
    end
    m_flags = e.flags;
    last_m  = e;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop(output exp_t e);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got=0 entries required>=1");
      e = last_m;
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic test_reset();
    exp_t e;
    reset_n = 1'b0;
    drive(4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    model_reset();
    #12 reset_n = 1'b1;
    drive(4'b1110, 4'b1111, 2'b11, 1, 0, 1, 1, 1, 4'hA, 0, 0);
    tick();
    pop(e);
    if (bus.RegWriteM !== e.regwrite || bus.FlagsQ !== e.flags || bus.WA3M !== e.wa3) begin
      errors++;
      $display("FAIL pre_reset_load got=%b/%b/%h required=%b/%b/%h",
               bus.RegWriteM, bus.FlagsQ, bus.WA3M, e.regwrite, e.flags, e.wa3);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.FlagsQ !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b required=0000", bus.FlagsQ);
    end
    checks++;
    if ({bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b required=0000",
               {bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM});
    end
    checks++;
    if (bus.WA3M !== 4'h0) begin
      errors++; $display("FAIL reset_wa3 got=%h required=0", bus.WA3M);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    $display("reset: flags=%b m=%b%b%b%b wa3=%h", bus.FlagsQ, bus.PCSrcM,
             bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.WA3M);
  endtask

  task automatic test_set_flags();
    exp_t e;
    drive(4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick(); pop(e);
    if (bus.FlagsQ !== e.flags) begin
      errors++; $display("FAIL set_flags got=%b required=%b", bus.FlagsQ, e.flags);
    end
    drive(4'b0000, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 4'h1, 0, 0);
    #1;
    checks++;
    if (bus.CondExE !== sb[$].condex) begin
      errors++; $display("FAIL eq_condex got=%b required=%b", bus.CondExE, sb[$].condex);
    end
    tick(); pop(e);
    if (bus.RegWriteM !== e.regwrite) begin
      errors++; $display("FAIL eq_regwrite got=%b required=%b", bus.RegWriteM, e.regwrite);
    end
    drive(4'b0001, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 4'h2, 0, 0);
    tick(); pop(e);
    if (bus.RegWriteM !== e.regwrite) begin
      errors++; $display("FAIL ne_regwrite got=%b required=%b", bus.RegWriteM, e.regwrite);
    end
    $display("set_flags: flags=%b regwrite=%b", bus.FlagsQ, bus.RegWriteM);
  endtask

  task automatic test_partial_write();
    exp_t e;
    drive(4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick(); pop(e);
    drive(4'b1110, 4'b0000, 2'b10, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick(); pop(e);
    if (bus.FlagsQ !== e.flags) begin
      errors++; $display("FAIL partial_write got=%b required=%b", bus.FlagsQ, e.flags);
    end
    $display("partial_write: flags=%b", bus.FlagsQ);
  endtask

  task automatic test_failed_cond();
    exp_t e;
    drive(4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick(); pop(e);
    drive(4'b0000, 4'b1111, 2'b11, 1, 1, 1, 1, 1, 4'h5, 0, 0);
    #1;
    checks++;
    if (bus.BranchTakenE !== sb[$].btaken) begin
      errors++; $display("FAIL failed_btaken got=%b required=%b", bus.BranchTakenE, sb[$].btaken);
    end
    tick(); pop(e);
    if ({bus.PCSrcM, bus.RegWriteM, bus.MemWriteM} !== {e.pcsrc, e.regwrite, e.memwrite} ||
        bus.FlagsQ !== e.flags || bus.MemtoRegM !== e.memtoreg || bus.WA3M !== e.wa3) begin
      errors++;
      $display("FAIL failed_bubble got=%b%b%b f=%b m2r=%b wa=%h required=%b%b%b f=%b m2r=%b wa=%h",
               bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.FlagsQ, bus.MemtoRegM, bus.WA3M,
               e.pcsrc, e.regwrite, e.memwrite, e.flags, e.memtoreg, e.wa3);
    end
    $display("failed_cond: memwrite=%b flags=%b wa3=%h", bus.MemWriteM, bus.FlagsQ, bus.WA3M);
  endtask

  task automatic test_signed();
    exp_t e;
    logic [3:0] conds_a [3];
    logic [3:0] conds_b [2];
    conds_a = '{4'b1010, 4'b1011, 4'b1100};
    conds_b = '{4'b1010, 4'b1101};
    drive(4'b1110, 4'b1001, 2'b11, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick(); pop(e);
    foreach (conds_a[i]) begin
      drive(conds_a[i], 4'b0000, 2'b00, 0, 0, 1, 0, 0, 4'h3, 0, 0);
      tick(); pop(e);
      if (bus.RegWriteM !== e.regwrite) begin
        errors++;
        $display("FAIL signed_1001 cond=%b got=%b required=%b", conds_a[i], bus.RegWriteM, e.regwrite);
      end
    end
    drive(4'b1110, 4'b1000, 2'b11, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    tick(); pop(e);
    foreach (conds_b[i]) begin
      drive(conds_b[i], 4'b0000, 2'b00, 0, 0, 1, 0, 0, 4'h4, 0, 0);
      tick(); pop(e);
      if (bus.RegWriteM !== e.regwrite) begin
        errors++;
        $display("FAIL signed_1000 cond=%b got=%b required=%b", conds_b[i], bus.RegWriteM, e.regwrite);
      end
    end
    $display("signed: flags=%b", bus.FlagsQ);
  endtask

  task automatic test_stall_flush();
    exp_t e;
    drive(4'b1110, 4'b0110, 2'b11, 1, 0, 1, 1, 1, 4'h3, 0, 0);
    tick(); pop(e);
    drive(4'b1110, 4'b1001, 2'b11, 0, 0, 0, 0, 0, 4'h9, 1, 0);
    tick(); pop(e);
    if ({bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM} !==
        {e.pcsrc, e.regwrite, e.memwrite, e.memtoreg} || bus.WA3M !== e.wa3 ||
        bus.FlagsQ !== e.flags) begin
      errors++;
      $display("FAIL stall_hold got=%b%b%b%b wa=%h f=%b required=%b%b%b%b wa=%h f=%b",
               bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.WA3M, bus.FlagsQ,
               e.pcsrc, e.regwrite, e.memwrite, e.memtoreg, e.wa3, e.flags);
    end
    drive(4'b1110, 4'b1001, 2'b11, 1, 0, 1, 1, 1, 4'h9, 1, 1);
    tick(); pop(e);
    if ({bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM} !==
        {e.pcsrc, e.regwrite, e.memwrite, e.memtoreg} || bus.WA3M !== e.wa3 ||
        bus.FlagsQ !== e.flags) begin
      errors++;
      $display("FAIL stall_flush got=%b%b%b%b wa=%h f=%b required=%b%b%b%b wa=%h f=%b",
               bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.WA3M, bus.FlagsQ,
               e.pcsrc, e.regwrite, e.memwrite, e.memtoreg, e.wa3, e.flags);
    end
    $display("stall_flush: m=%b%b%b%b flags=%b", bus.PCSrcM, bus.RegWriteM,
             bus.MemWriteM, bus.MemtoRegM, bus.FlagsQ);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 80; i++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      #1;
      checks++;
      if (bus.CondExE !== sb[$].condex || bus.BranchTakenE !== sb[$].btaken) begin
        errors++;
        $display("FAIL b2b_comb i=%0d cond=%b got=%b%b required=%b%b", i, bus.CondE,
                 bus.CondExE, bus.BranchTakenE, sb[$].condex, sb[$].btaken);
      end
      tick(); pop(e);
      if ({bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM} !==
          {e.pcsrc, e.regwrite, e.memwrite, e.memtoreg} || bus.WA3M !== e.wa3 ||
          bus.FlagsQ !== e.flags) begin
        errors++;
        $display("FAIL b2b_state i=%0d got=%b%b%b%b wa=%h f=%b required=%b%b%b%b wa=%h f=%b", i,
                 bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.WA3M, bus.FlagsQ,
                 e.pcsrc, e.regwrite, e.memwrite, e.memtoreg, e.wa3, e.flags);
      end
      $display("b2b %0d: m=%b%b%b%b wa3=%h flags=%b", i, bus.PCSrcM, bus.RegWriteM,
               bus.MemWriteM, bus.MemtoRegM, bus.WA3M, bus.FlagsQ);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_set_flags();
    test_partial_write();
    test_failed_cond();
    test_signed();
    test_stall_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
